// File: rtl/int_ctrl_pkg.sv
// Shared constants for the CP0-side interrupt path: exception codes, interrupt width
// and the word offsets of the interrupt controller register window.
package int_ctrl_pkg;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Matches the CP0 HWInt width
    localparam int N_IRQ = 6;

    localparam logic [1:0] OFF_MODE   = 2'd0;
    localparam logic [1:0] OFF_ENABLE = 2'd1;
    localparam logic [1:0] OFF_PEND   = 2'd2;
    localparam logic [1:0] OFF_INSERV = 2'd3;

    typedef logic [N_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/int_ctrl_prio_pick.sv
// Combinational fixed-priority selector: one-hot grant of the top requester and the
// mask of every line at or below that requester's priority.
module int_ctrl_prio_pick
    import int_ctrl_pkg::*;
#(
    parameter bit PRIO_LOW_FIRST = 1'b1
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [N_IRQ-1:0] grant_o,
    output logic [N_IRQ-1:0] below_o
);

    irq_vec_t req_ord;
    irq_vec_t grant_ord;
    irq_vec_t below_ord;

    genvar gi;

    // Reorder so index 0 is always the highest priority, then isolate the lowest set bit.
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_ord
            localparam int LINE = PRIO_LOW_FIRST ? gi : (N_IRQ - 1 - gi);
            assign req_ord[gi]  = req_i[LINE];
            assign grant_o[LINE] = grant_ord[gi];
            assign below_o[LINE] = below_ord[gi];
        end
    endgenerate

    assign grant_ord = req_ord & (~req_ord + irq_vec_t'(1));
    // Zero grant yields an all-zero mask because ~(0 - 1) wraps to zero.
    assign below_ord = ~(grant_ord - irq_vec_t'(1));

endmodule

// File: rtl/int_ctrl.sv
// Interrupt aggregator in front of CP0 HWInt: per-line sync and level/edge capture,
// sticky pending bits, and fixed-priority nesting through an in-service register.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [N_IRQ-1:0] SYNC_MASK      = 6'b111000,
    parameter bit               PRIO_LOW_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_ack,
    input  logic [1:0]       bus_addr,
    input  logic             bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic [N_IRQ-1:0] hwint,
    output logic             in_service
);

    irq_vec_t sync_val;
    irq_vec_t prev_q;
    irq_vec_t edge_det;

    irq_vec_t mode_q, mode_d;
    irq_vec_t enable_q, enable_d;
    irq_vec_t pend_q, pend_d;
    irq_vec_t inserv_q, inserv_d;
    irq_vec_t hwint_q, hwint_d;

    irq_vec_t ack_sel;
    irq_vec_t eoi_sel;
    irq_vec_t blk;
    irq_vec_t w1c;
    irq_vec_t ack_clr;
    logic     ack_fire;
    logic     eoi;

    irq_vec_t unused_ack_below;
    irq_vec_t unused_eoi_below;
    irq_vec_t unused_blk_grant;
    logic     unused_wdata;

    genvar gi;

    // Asynchronous sources get a two-flop chain; on-chip sources are used as-is.
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            if (SYNC_MASK[gi]) begin : g_sync
                logic [1:0] chain_q;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        chain_q <= 2'b00;
                    end else begin
                        chain_q <= {chain_q[0], irq_in[gi]};
                    end
                end
                assign sync_val[gi] = chain_q[1];
            end else begin : g_direct
                assign sync_val[gi] = irq_in[gi];
            end
        end
    endgenerate

    assign edge_det = sync_val & ~prev_q;

    int_ctrl_prio_pick #(.PRIO_LOW_FIRST(PRIO_LOW_FIRST)) u_pick_ack (
        .req_i   (hwint_q),
        .grant_o (ack_sel),
        .below_o (unused_ack_below)
    );

    int_ctrl_prio_pick #(.PRIO_LOW_FIRST(PRIO_LOW_FIRST)) u_pick_blk (
        .req_i   (inserv_q),
        .grant_o (unused_blk_grant),
        .below_o (blk)
    );

    int_ctrl_prio_pick #(.PRIO_LOW_FIRST(PRIO_LOW_FIRST)) u_pick_eoi (
        .req_i   (inserv_q),
        .grant_o (eoi_sel),
        .below_o (unused_eoi_below)
    );

    assign unused_wdata = ^bus_wdata[31:N_IRQ];

    assign ack_fire = int_ack & (|hwint_q);
    assign eoi      = bus_we && (bus_addr == OFF_INSERV);
    assign w1c      = (bus_we && (bus_addr == OFF_PEND)) ? bus_wdata[N_IRQ-1:0] : '0;
    assign ack_clr  = ack_fire ? (ack_sel & mode_q) : '0;

    always_comb begin
        mode_d   = mode_q;
        enable_d = enable_q;
        if (bus_we && (bus_addr == OFF_MODE)) begin
            mode_d = bus_wdata[N_IRQ-1:0];
        end
        if (bus_we && (bus_addr == OFF_ENABLE)) begin
            enable_d = bus_wdata[N_IRQ-1:0];
        end

        // Edge lines latch (a new edge beats any clear); level lines mirror the source.
        pend_d = (mode_q & (edge_det | (pend_q & ~w1c & ~ack_clr)))
               | (~mode_q & sync_val);

        // EOI retires the current top bit before the ack bit is added.
        inserv_d = inserv_q & ~(eoi ? eoi_sel : '0);
        if (ack_fire) begin
            inserv_d = inserv_d | ack_sel;
        end

        hwint_d = pend_q & enable_q & ~blk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            mode_q   <= '0;
            enable_q <= '0;
            pend_q   <= '0;
            inserv_q <= '0;
            hwint_q  <= '0;
        end else begin
            prev_q   <= sync_val;
            mode_q   <= mode_d;
            enable_q <= enable_d;
            pend_q   <= pend_d;
            inserv_q <= inserv_d;
            hwint_q  <= hwint_d;
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            OFF_MODE:   bus_rdata[N_IRQ-1:0] = mode_q;
            OFF_ENABLE: bus_rdata[N_IRQ-1:0] = enable_q;
            OFF_PEND:   bus_rdata[N_IRQ-1:0] = pend_q;
            default:    bus_rdata[N_IRQ-1:0] = inserv_q;
        endcase
    end

    assign hwint      = hwint_q;
    assign in_service = |inserv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: register table, directed nesting/latency sequences, then
// randomized traffic against a priority-rank reference model.
module tb_int_ctrl;

    localparam logic [5:0] SYNC      = 6'b111000;
    localparam bit         LOW_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic        int_ack;
    logic [1:0]  bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [5:0]  hwint;
    logic        in_service;

    int checks = 0;
    int errors = 0;

    int_ctrl #(.SYNC_MASK(SYNC), .PRIO_LOW_FIRST(LOW_FIRST)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .int_ack    (int_ack),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .hwint      (hwint),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        cyc(1);
        bus_we = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_addr = a;
        #1;
        chk(name, bus_rdata, exp);
    endtask

    // ---------------- reference model ----------------
    logic [5:0] m_mode, m_en, m_pend, m_ins, m_hw;
    logic [5:0] hist [1:3];

    function automatic int rank(input int i);
        return LOW_FIRST ? i : 5 - i;
    endfunction

    function automatic int top_of(input logic [5:0] x);
        int best = -1;
        for (int i = 0; i < 6; i++)
            if (x[i] && (best < 0 || rank(i) < rank(best))) best = i;
        return best;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return {26'd0, m_mode};
            2'd1: return {26'd0, m_en};
            2'd2: return {26'd0, m_pend};
            default: return {26'd0, m_ins};
        endcase
    endfunction

    task automatic model_step();
        logic [5:0] sv, sp, edg, w1c, blk, npend, nins;
        int sel, t;
        if (reset) begin
            m_mode = '0; m_en = '0; m_pend = '0; m_ins = '0; m_hw = '0;
            hist[1] = '0; hist[2] = '0; hist[3] = '0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            sv[i] = SYNC[i] ? hist[2][i] : irq_in[i];
            sp[i] = SYNC[i] ? hist[3][i] : hist[1][i];
        end
        edg = sv & ~sp;
        w1c = (bus_we && bus_addr == 2'd2) ? bus_wdata[5:0] : 6'd0;
        sel = top_of(m_hw);
        nins = m_ins;
        if (bus_we && bus_addr == 2'd3 && m_ins != 0) nins[top_of(m_ins)] = 1'b0;
        if (int_ack && sel >= 0) nins[sel] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) npend[i] = edg[i] | (m_pend[i] & !w1c[i] & !(int_ack && sel == i));
            else           npend[i] = sv[i];
        end
        blk = '0;
        if (m_ins != 0) begin
            t = top_of(m_ins);
            for (int i = 0; i < 6; i++) blk[i] = (rank(i) >= rank(t));
        end
        m_hw = m_pend & m_en & ~blk;
        if (bus_we && bus_addr == 2'd0) m_mode = bus_wdata[5:0];
        if (bus_we && bus_addr == 2'd1) m_en = bus_wdata[5:0];
        m_pend = npend;
        m_ins  = nins;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = irq_in;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        reset = 1'b1; irq_in = '0; int_ack = 1'b0;
        bus_addr = '0; bus_we = 1'b0; bus_wdata = '0;
        cyc(2);
        reset = 1'b0;

        // Reset state
        chk("rst_hwint", {26'd0, hwint}, 32'h0);
        chk("rst_in_service", {31'd0, in_service}, 32'h0);
        for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'h0);

        // Register write/readback table
        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h3F};
        vecs[1] = '{2'd0, 32'h0000_002A, 32'h2A};
        vecs[2] = '{2'd1, 32'hFFFF_FFC0, 32'h00};
        vecs[3] = '{2'd1, 32'h0000_0015, 32'h15};
        vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'h00};
        vecs[5] = '{2'd3, 32'hFFFF_FFFF, 32'h00};
        vecs[6] = '{2'd0, 32'h0000_0000, 32'h00};
        vecs[7] = '{2'd1, 32'h0000_0000, 32'h00};
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd($sformatf("table%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Level line 0: visible two cycles after ENABLE write, gone two cycles after drop
        irq_in = 6'h01;
        cyc(1);
        wr(2'd1, 32'h3F);
        chk("lvl_hw_t1", {26'd0, hwint}, 32'h00);
        cyc(1);
        chk("lvl_hw_t2", {26'd0, hwint}, 32'h01);
        irq_in = 6'h00;
        cyc(1);
        chk("lvl_drop_t1", {26'd0, hwint}, 32'h01);
        cyc(1);
        chk("lvl_drop_t2", {26'd0, hwint}, 32'h00);

        // Synced edge on line 3: four-cycle latency, W1C clears
        wr(2'd0, 32'h08);
        irq_in = 6'h08;
        cyc(1);
        irq_in = 6'h00;
        cyc(2);
        chk("edge3_t3", {26'd0, hwint}, 32'h00);
        cyc(1);
        chk("edge3_t4", {26'd0, hwint}, 32'h08);
        rd("edge3_pend", 2'd2, 32'h08);
        wr(2'd2, 32'h08);
        chk("w1c_t1", {26'd0, hwint}, 32'h08);
        cyc(1);
        chk("w1c_t2", {26'd0, hwint}, 32'h00);
        rd("w1c_pend", 2'd2, 32'h00);

        // Edges on lines 1 and 4; ack takes line 1 and blocks line 4
        wr(2'd0, 32'h12);
        irq_in = 6'h12;
        cyc(1);
        irq_in = 6'h00;
        cyc(3);
        chk("dual_hw", {26'd0, hwint}, 32'h12);
        ack();
        rd("ack1_inserv", 2'd3, 32'h02);
        rd("ack1_pend", 2'd2, 32'h10);
        chk("ack1_in_service", {31'd0, in_service}, 32'h1);
        cyc(1);
        chk("ack1_blocked", {26'd0, hwint}, 32'h00);
        wr(2'd3, 32'h0);
        cyc(1);
        chk("eoi1_hw", {26'd0, hwint}, 32'h10);

        // Nesting: line 4 in service, line 0 preempts
        ack();
        rd("nest_ins4", 2'd3, 32'h10);
        irq_in = 6'h01;
        cyc(2);
        chk("nest_hw0", {26'd0, hwint}, 32'h01);
        ack();
        rd("nest_ins11", 2'd3, 32'h11);
        irq_in = 6'h00;
        wr(2'd3, 32'h0);
        rd("nest_eoi_a", 2'd3, 32'h10);
        wr(2'd3, 32'h0);
        rd("nest_eoi_b", 2'd3, 32'h00);
        chk("nest_in_service", {31'd0, in_service}, 32'h0);

        // Set beats W1C on line 2; ack with hwint=0 ignored
        wr(2'd0, 32'h04);
        irq_in = 6'h04;
        cyc(1);
        irq_in = 6'h00;
        cyc(1);
        rd("l2_pend", 2'd2, 32'h04);
        irq_in = 6'h04;
        wr(2'd2, 32'h04);
        rd("set_wins", 2'd2, 32'h04);
        cyc(1);
        chk("l2_hw", {26'd0, hwint}, 32'h04);
        ack();
        rd("l2_ack_pend", 2'd2, 32'h00);
        cyc(1);
        chk("l2_hw_zero", {26'd0, hwint}, 32'h00);
        ack();
        rd("null_ack_ins", 2'd3, 32'h04);
        wr(2'd3, 32'h0);
        irq_in = 6'h00;

        // Reset with INSERV=05 and an edge mid-synchroniser
        wr(2'd0, 32'h24);
        irq_in = 6'h04;
        cyc(1);
        irq_in = 6'h00;
        cyc(1);
        chk("r_hw4", {26'd0, hwint}, 32'h04);
        ack();
        irq_in = 6'h01;
        cyc(2);
        chk("r_hw1", {26'd0, hwint}, 32'h01);
        ack();
        rd("r_ins05", 2'd3, 32'h05);
        irq_in = 6'h21;
        cyc(1);
        reset = 1'b1; irq_in = 6'h00;
        cyc(1);
        reset = 1'b0;
        chk("r_hwint", {26'd0, hwint}, 32'h0);
        chk("r_in_service", {31'd0, in_service}, 32'h0);
        for (int a = 0; a < 4; a++) rd("r_reg", 2'(a), 32'h0);
        wr(2'd1, 32'h3F);
        wr(2'd0, 32'h20);
        cyc(4);
        chk("r_no_ghost_hw", {26'd0, hwint}, 32'h0);
        rd("r_no_ghost_pend", 2'd2, 32'h0);

        // Randomized traffic against the reference model
        m_mode = '0; m_en = '0; m_pend = '0; m_ins = '0; m_hw = '0;
        hist[1] = '0; hist[2] = '0; hist[3] = '0;
        for (int n = 0; n < 1500; n++) begin
            reset     = (n == 0) || ($urandom_range(0, 299) == 0);
            irq_in    = irq_in ^ (($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00);
            int_ack   = ($urandom_range(0, 3) == 0);
            bus_we    = ($urandom_range(0, 4) == 0);
            bus_addr  = 2'($urandom);
            bus_wdata = $urandom;
            @(negedge clk);
            if (n > 0) begin
                chk("rnd_hwint", {26'd0, hwint}, {26'd0, m_hw});
                chk("rnd_in_service", {31'd0, in_service}, {31'd0, (m_ins != 0)});
                chk("rnd_rdata", bus_rdata, m_read(bus_addr));
            end
            model_step();
            @(posedge clk);
            #1;
        end
        reset = 1'b0; bus_we = 1'b0; int_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
